// File: rtl/display_pkg.sv
// Shared constants and helpers for the 7-segment display scanners.
// Glyph codes are the values the downstream hex/glyph decoder understands.
package display_pkg;

   localparam logic [3:0] BLANK_CODE   = 4'hA;
   localparam logic [3:0] DEGREE_CODE  = 4'hE;
   localparam logic [3:0] CELSIUS_CODE = 4'hC;

   // Where the active buffer is refreshed from at a frame boundary.
   typedef enum logic [1:0] {
      COMMIT_NONE,
      COMMIT_PENDING,
      COMMIT_BYPASS
   } commit_src_e;

   // Counter width for a range of 'value' states; never narrower than 1 bit.
   function automatic int clog2(input int value);
      int result;
      result = 1;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running divider: one-cycle tick every PRESCALE clocks.
// Shared by the temperature and clock-display scanners.
module scan_prescaler
   import display_pkg::*;
#(
   parameter int PRESCALE = 50000
)
(
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CNT_W = clog2(PRESCALE);
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] r_count;

   // The >= lets a corrupted count fall back to zero on the very next edge.
   assign tick = (r_count >= LAST_COUNT);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (tick) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule

// File: rtl/display_scan_mux.sv
// N-digit 7-segment scan driver: double-buffered frame, tear-free commits,
// leading-zero blanking and per-digit blink, one registered code per scan slot.
module display_scan_mux #(
   parameter int NUM_DIGITS   = 8,
   parameter int CODE_W       = 4,
   parameter int PRESCALE     = 50000,
   parameter int BLINK_FRAMES = 64,
   parameter logic [CODE_W-1:0] BLANK_CODE = CODE_W'(display_pkg::BLANK_CODE)
)
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_DIGITS*CODE_W-1:0] frame_in,
   input  logic                         frame_load,
   input  logic                         lz_en,
   input  logic [NUM_DIGITS-1:0]        blink_mask,
   output logic [CODE_W-1:0]            code_out,
   output logic [NUM_DIGITS-1:0]        digit_sel,
   output logic                         frame_start,
   output logic                         load_ack
);

   import display_pkg::*;

   localparam int IDX_W = clog2(NUM_DIGITS);
   localparam int FRM_W = clog2(BLINK_FRAMES);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [FRM_W-1:0] LAST_FRAME = FRM_W'(BLINK_FRAMES - 1);

   typedef logic [NUM_DIGITS-1:0][CODE_W-1:0] frame_t;

   logic                  w_tick;
   logic                  w_boundary;
   logic [IDX_W-1:0]      w_nextIdx;
   logic [NUM_DIGITS-1:0] w_nextSel;
   commit_src_e           w_commitSrc;
   frame_t                w_newActive;
   logic [NUM_DIGITS-1:0] w_newLzMask;
   logic [NUM_DIGITS-1:0] w_slotLzMask;
   logic [FRM_W-1:0]      w_nextFrameCount;
   logic                  w_nextPhase;
   logic [CODE_W-1:0]     w_slotCode;

   logic [IDX_W-1:0]      r_idx;
   frame_t                r_active;
   frame_t                r_pending;
   logic                  r_pendingFlag;
   logic [NUM_DIGITS-1:0] r_lzMask;
   logic [FRM_W-1:0]      r_frameCount;
   logic                  r_phase;
   logic [CODE_W-1:0]     r_codeOut;
   logic [NUM_DIGITS-1:0] r_digitSel;
   logic                  r_frameStart;
   logic                  r_loadAck;

   scan_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .tick (w_tick)
   );

   assign w_boundary = w_tick && (r_idx >= LAST_IDX);
   assign w_nextIdx  = (r_idx >= LAST_IDX) ? '0 : r_idx + 1'b1;
   assign w_nextSel  = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << w_nextIdx;

   // A load landing on the boundary cycle bypasses the pending buffer.
   always_comb begin
      w_commitSrc = COMMIT_NONE;
      w_newActive = r_active;
      if (w_boundary) begin
         if (frame_load) begin
            w_commitSrc = COMMIT_BYPASS;
            w_newActive = frame_in;
         end else if (r_pendingFlag) begin
            w_commitSrc = COMMIT_PENDING;
            w_newActive = r_pending;
         end
      end
   end

   always_comb begin
      logic seenNonZero;
      seenNonZero = 1'b0;
      w_newLzMask = '0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         if (w_newActive[i] != '0) begin
            seenNonZero = 1'b1;
         end
         w_newLzMask[i] = ~seenNonZero;
      end
   end

   // Slot 0 of a new frame must already see the freshly committed data.
   assign w_slotLzMask = w_boundary ? w_newLzMask : r_lzMask;

   always_comb begin
      w_nextFrameCount = r_frameCount;
      w_nextPhase      = r_phase;
      if (w_boundary) begin
         if (r_frameCount >= LAST_FRAME) begin
            w_nextFrameCount = '0;
            w_nextPhase      = ~r_phase;
         end else begin
            w_nextFrameCount = r_frameCount + 1'b1;
         end
      end
   end

   always_comb begin
      w_slotCode = w_newActive[w_nextIdx];
      if (w_nextPhase && blink_mask[w_nextIdx]) begin
         w_slotCode = BLANK_CODE;
      end else if (lz_en && w_slotLzMask[w_nextIdx]) begin
         w_slotCode = BLANK_CODE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_active      <= {NUM_DIGITS{BLANK_CODE}};
         r_pending     <= {NUM_DIGITS{BLANK_CODE}};
         r_pendingFlag <= 1'b0;
         r_lzMask      <= '0;
         r_loadAck     <= 1'b0;
      end else begin
         r_loadAck <= (w_commitSrc != COMMIT_NONE);
         if (w_commitSrc != COMMIT_NONE) begin
            r_active      <= w_newActive;
            r_lzMask      <= w_newLzMask;
            r_pendingFlag <= 1'b0;
         end else if (frame_load) begin
            r_pending     <= frame_in;
            r_pendingFlag <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx        <= '0;
         r_frameCount <= '0;
         r_phase      <= 1'b0;
         r_codeOut    <= BLANK_CODE;
         r_digitSel   <= {{(NUM_DIGITS-1){1'b0}}, 1'b1};
         r_frameStart <= 1'b0;
      end else begin
         r_frameCount <= w_nextFrameCount;
         r_phase      <= w_nextPhase;
         r_frameStart <= w_boundary;
         if (w_tick) begin
            r_idx      <= w_nextIdx;
            r_codeOut  <= w_slotCode;
            r_digitSel <= w_nextSel;
         end
      end
   end

   assign code_out    = r_codeOut;
   assign digit_sel   = r_digitSel;
   assign frame_start = r_frameStart;
   assign load_ack    = r_loadAck;

endmodule

// File: tb/tb_display_scan_mux.sv
// Randomized bench for display_scan_mux, checked every cycle against a
// slot/frame arithmetic model of the scanner.
module tb_display_scan_mux;

   localparam int NUM_DIGITS   = 8;
   localparam int CODE_W       = 4;
   localparam int PRESCALE     = 4;
   localparam int BLINK_FRAMES = 2;
   localparam int FRAME_CYCLES = NUM_DIGITS * PRESCALE;
   localparam logic [3:0] BLANK = 4'hA;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] frame_in;
   logic        frame_load;
   logic        lz_en;
   logic [7:0]  blink_mask;
   logic [3:0]  code_out;
   logic [7:0]  digit_sel;
   logic        frame_start;
   logic        load_ack;

   always #5 clk = ~clk;

   display_scan_mux #(
      .NUM_DIGITS   (NUM_DIGITS),
      .CODE_W       (CODE_W),
      .PRESCALE     (PRESCALE),
      .BLINK_FRAMES (BLINK_FRAMES),
      .BLANK_CODE   (BLANK)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .frame_in    (frame_in),
      .frame_load  (frame_load),
      .lz_en       (lz_en),
      .blink_mask  (blink_mask),
      .code_out    (code_out),
      .digit_sel   (digit_sel),
      .frame_start (frame_start),
      .load_ack    (load_ack)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Model: edgeCount = clock edges since reset released; everything else
   // (slot, digit, frame number, blink phase) is derived arithmetically.
   int         edgeCount;
   logic [3:0] activeDigit [NUM_DIGITS];
   bit         pendingValid;
   logic [31:0] pendingFrame;
   logic [3:0] expCode;
   logic [7:0] expSel;
   logic       expStart;
   logic       expAck;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %0h, expected %0h at t=%0t",
                  tag, observed, expected, $time);
      end
   endtask

   function automatic void loadActive(input logic [31:0] frame);
      for (int d = 0; d < NUM_DIGITS; d++) begin
         activeDigit[d] = frame[d*4 +: 4];
      end
   endfunction

   function automatic void modelReset();
      edgeCount    = 0;
      pendingValid = 1'b0;
      pendingFrame = '0;
      for (int d = 0; d < NUM_DIGITS; d++) activeDigit[d] = BLANK;
      expCode  = BLANK;
      expSel   = 8'h01;
      expStart = 1'b0;
      expAck   = 1'b0;
   endfunction

   function automatic void modelEdge();
      bit tick, boundary, phase, leadingZero;
      int digit, frameNo;
      tick     = (edgeCount % PRESCALE) == PRESCALE - 1;
      boundary = ((edgeCount + 1) % FRAME_CYCLES) == 0;
      expStart = boundary;
      expAck   = 1'b0;
      if (boundary && frame_load) begin
         loadActive(frame_in);
         pendingValid = 1'b0;
         expAck = 1'b1;
      end else if (boundary && pendingValid) begin
         loadActive(pendingFrame);
         pendingValid = 1'b0;
         expAck = 1'b1;
      end else if (frame_load) begin
         pendingValid = 1'b1;
         pendingFrame = frame_in;
      end
      if (tick) begin
         digit   = ((edgeCount + 1) / PRESCALE) % NUM_DIGITS;
         frameNo = (edgeCount + 1) / FRAME_CYCLES;
         phase   = ((frameNo / BLINK_FRAMES) % 2) == 1;
         leadingZero = lz_en && (digit != 0);
         for (int j = digit; j < NUM_DIGITS; j++) begin
            if (activeDigit[j] != 4'h0) leadingZero = 1'b0;
         end
         if (phase && blink_mask[digit]) expCode = BLANK;
         else if (leadingZero)           expCode = BLANK;
         else                            expCode = activeDigit[digit];
         expSel = 8'(1 << digit);
      end
      edgeCount++;
   endfunction

   function automatic int currentDigit();
      return (edgeCount / PRESCALE) % NUM_DIGITS;
   endfunction

   function automatic bit nextEdgeIsBoundary();
      return ((edgeCount + 1) % FRAME_CYCLES) == 0;
   endfunction

   function automatic logic [31:0] randomFrame();
      logic [31:0] f;
      int zeroTop;
      zeroTop = $urandom_range(0, NUM_DIGITS);
      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (d >= NUM_DIGITS - zeroTop || $urandom_range(0, 2) == 0) f[d*4 +: 4] = 4'h0;
         else f[d*4 +: 4] = 4'($urandom_range(0, 15));
      end
      return f;
   endfunction

   // Drives one cycle of inputs, advances the model, checks all outputs.
   task automatic applyStimulus(input bit load, input logic [31:0] frame);
      frame_load = load;
      frame_in   = load ? frame : 32'($urandom);
      @(posedge clk);
      if (rst) modelReset();
      else     modelEdge();
      @(negedge clk);
      checkOutput("code_out",    32'(code_out),    32'(expCode));
      checkOutput("digit_sel",   32'(digit_sel),   32'(expSel));
      checkOutput("frame_start", 32'(frame_start), 32'(expStart));
      checkOutput("load_ack",    32'(load_ack),    32'(expAck));
   endtask

   task automatic idle(input int cycles);
      for (int k = 0; k < cycles; k++) applyStimulus(1'b0, '0);
   endtask

   task automatic loadOnBoundary(input logic [31:0] frame);
      for (int k = 0; k < FRAME_CYCLES && !nextEdgeIsBoundary(); k++) applyStimulus(1'b0, '0);
      applyStimulus(1'b1, frame);
   endtask

   task automatic idleUntilDigit(input int digit);
      for (int k = 0; k < FRAME_CYCLES && currentDigit() != digit; k++) applyStimulus(1'b0, '0);
   endtask

   initial begin
      rst        = 1'b1;
      frame_in   = '0;
      frame_load = 1'b0;
      lz_en      = 1'b0;
      blink_mask = '0;
      modelReset();

      idle(3);
      rst = 1'b0;

      applyStimulus(1'b1, 32'hAAAA25EC);
      idle(3 * FRAME_CYCLES);

      idleUntilDigit(3);
      idle(1);
      applyStimulus(1'b1, 32'h12345678);
      idle(2 * FRAME_CYCLES);

      idleUntilDigit(5);
      applyStimulus(1'b1, 32'h11111111);
      applyStimulus(1'b1, 32'h87654321);
      idle(FRAME_CYCLES);
      loadOnBoundary(32'h9999ABCD);
      idle(FRAME_CYCLES);

      lz_en = 1'b1;
      applyStimulus(1'b1, 32'h00000407);
      idle(2 * FRAME_CYCLES);
      applyStimulus(1'b1, 32'h00000000);
      idle(2 * FRAME_CYCLES);

      lz_en      = 1'b0;
      blink_mask = 8'h0C;
      applyStimulus(1'b1, 32'h76543210);
      idle(5 * FRAME_CYCLES);

      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 19) == 0) lz_en = 1'($urandom);
         if ($urandom_range(0, 19) == 0) blink_mask = 8'($urandom);
         if ($urandom_range(0, 39) == 0) loadOnBoundary(randomFrame());
         else applyStimulus($urandom_range(0, 11) == 0, randomFrame());
      end

      idleUntilDigit(4);
      applyStimulus(1'b1, 32'h31415926);
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(3 * FRAME_CYCLES);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
